rx_page_ctrl: RTL and testbench

// - Schedules the RX pages of the pp_ram between the byte receiver (writer) and the host register interface (reader).
// - Owns the write-page index, a ring of filled pages with per-page wr_flags, and page-overflow ("lost") detection.
// - Issues abort to the receiver on host clean.
// - Counts lost and error frames for the control center.

---
 rtl/rx_page_ctrl_pkg.sv | 12 +
 rtl/rx_flag_ram.sv | 31 +++
 rtl/rx_page_ctrl.sv | 108 ++++++++++
 tb/tb_rx_page_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_page_ctrl_pkg.sv
// Shared definitions for the RX page controller and the byte receiver.
package rx_page_ctrl_pkg;

    localparam logic [7:0] RX_FLAG_OK  = 8'h00;
    localparam logic [7:0] RX_FLAG_OVF = 8'hff;
    localparam logic [7:0] CNT_MAX     = 8'hff;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rx_flag_ram.sv
// Per-page wr_flags register file: one synchronous write port, one async read port.
module rx_flag_ram
    import rx_page_ctrl_pkg::*;
#(
    parameter int PAGES = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [PW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [PAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PAGES; i++) begin
                mem[i] <= RX_FLAG_OK;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_page_ctrl.sv
// RX page scheduler: ring of filled pages between the byte receiver and the host reader.
module rx_page_ctrl
    import rx_page_ctrl_pkg::*;
#(
    parameter int PAGES = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_switch,
    input  logic [7:0]    rx_wr_flags,
    input  logic          rx_error,
    output logic          rx_abort,
    output logic [PW-1:0] wr_page,
    output logic [PW-1:0] rd_page,
    output logic [7:0]    rd_flags,
    output logic          rx_pending,
    input  logic          rd_done,
    input  logic          clean_all,
    output logic          rx_lost,
    output logic [7:0]    lost_cnt,
    output logic [7:0]    err_cnt,
    output logic [PW:0]   filled_cnt
);

    localparam int MAX_FILL_I = PAGES - 1;
    localparam logic [PW:0] MAX_FILL = MAX_FILL_I[PW:0];

    logic          rd_ok;
    logic          accept;
    logic          we;
    logic          lost_nx;
    logic [PW:0]   after_rd;
    logic [PW:0]   filled_nx;
    logic [PW-1:0] wr_nx;
    logic [PW-1:0] rd_nx;
    logic          pending_nx;
    logic [7:0]    ram_rdata;
    logic [7:0]    flags_nx;

    rx_flag_ram #(
        .PAGES (PAGES),
        .PW    (PW)
    ) u_flag_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (wr_page),
        .wdata   (rx_wr_flags),
        .raddr   (rd_nx),
        .rdata   (ram_rdata)
    );

    // Release is counted before the full check so a full ring can take a switch
    // in the same cycle as a read.
    always_comb begin
        rd_ok     = rd_done && rx_pending;
        after_rd  = filled_cnt - {{PW{1'b0}}, rd_ok};
        accept    = rx_switch && (after_rd < MAX_FILL);
        we        = accept && !clean_all;
        lost_nx   = rx_switch && !accept && !clean_all;
        wr_nx     = wr_page;
        rd_nx     = rd_page;
        filled_nx = filled_cnt;
        if (clean_all) begin
            wr_nx     = '0;
            rd_nx     = '0;
            filled_nx = '0;
        end else begin
            if (accept) wr_nx = wr_page + PW'(1);
            if (rd_ok)  rd_nx = rd_page + PW'(1);
            filled_nx = after_rd + {{PW{1'b0}}, accept};
        end
        pending_nx = (filled_nx != '0);
        // Bypass the write when the new read page is the one being written this cycle.
        if (!pending_nx)
            flags_nx = RX_FLAG_OK;
        else if (we && (wr_page == rd_nx))
            flags_nx = rx_wr_flags;
        else
            flags_nx = ram_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_page    <= '0;
            rd_page    <= '0;
            filled_cnt <= '0;
            rx_pending <= 1'b0;
            rd_flags   <= RX_FLAG_OK;
            rx_abort   <= 1'b0;
            rx_lost    <= 1'b0;
            lost_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            wr_page    <= wr_nx;
            rd_page    <= rd_nx;
            filled_cnt <= filled_nx;
            rx_pending <= pending_nx;
            rd_flags   <= flags_nx;
            rx_abort   <= clean_all;
            rx_lost    <= lost_nx;
            if (lost_nx)  lost_cnt <= sat_inc(lost_cnt);
            if (rx_error) err_cnt  <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_rx_page_ctrl.sv
// Self-checking bench for rx_page_ctrl: directed vector table plus random traffic against a queue model.
module tb_rx_page_ctrl;

    localparam int PAGES = 4;
    localparam int PW    = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_switch;
    logic [7:0]    rx_wr_flags;
    logic          rx_error;
    logic          rx_abort;
    logic [PW-1:0] wr_page;
    logic [PW-1:0] rd_page;
    logic [7:0]    rd_flags;
    logic          rx_pending;
    logic          rd_done;
    logic          clean_all;
    logic          rx_lost;
    logic [7:0]    lost_cnt;
    logic [7:0]    err_cnt;
    logic [PW:0]   filled_cnt;

    rx_page_ctrl #(
        .PAGES (PAGES),
        .PW    (PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_switch   (rx_switch),
        .rx_wr_flags (rx_wr_flags),
        .rx_error    (rx_error),
        .rx_abort    (rx_abort),
        .wr_page     (wr_page),
        .rd_page     (rd_page),
        .rd_flags    (rd_flags),
        .rx_pending  (rx_pending),
        .rd_done     (rd_done),
        .clean_all   (clean_all),
        .rx_lost     (rx_lost),
        .lost_cnt    (lost_cnt),
        .err_cnt     (err_cnt),
        .filled_cnt  (filled_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of flags for filled pages, oldest first.
    byte unsigned m_q[$];
    int           m_wr, m_rd, m_lost_cnt, m_err_cnt;
    bit           m_lost, m_abort;

    typedef struct {
        bit         sw;
        logic [7:0] fl;
        bit         dn;
        bit         cl;
        int         e_wr;
        int         e_rd;
        int         e_filled;
        int         e_flags;
        bit         e_lost;
        bit         e_abort;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wr = 0; m_rd = 0; m_lost_cnt = 0; m_err_cnt = 0;
        m_lost = 0; m_abort = 0;
    endtask

    task automatic model_update(input bit sw, input logic [7:0] fl, input bit er, input bit dn, input bit cl);
        m_lost  = 0;
        m_abort = cl;
        if (er && m_err_cnt < 255) m_err_cnt++;
        if (cl) begin
            m_q.delete();
            m_wr = 0;
            m_rd = 0;
        end else begin
            if (dn && m_q.size() > 0) begin
                void'(m_q.pop_front());
                m_rd = (m_rd + 1) % PAGES;
            end
            if (sw) begin
                if (m_q.size() < PAGES - 1) begin
                    m_q.push_back(fl);
                    m_wr = (m_wr + 1) % PAGES;
                end else begin
                    m_lost = 1;
                    if (m_lost_cnt < 255) m_lost_cnt++;
                end
            end
        end
    endtask

    task automatic check_model();
        check("wr_page",    int'(wr_page),    m_wr);
        check("rd_page",    int'(rd_page),    m_rd);
        check("filled_cnt", int'(filled_cnt), m_q.size());
        check("rx_pending", int'(rx_pending), int'(m_q.size() > 0));
        check("rd_flags",   int'(rd_flags),   (m_q.size() > 0) ? int'(m_q[0]) : 0);
        check("rx_lost",    int'(rx_lost),    int'(m_lost));
        check("rx_abort",   int'(rx_abort),   int'(m_abort));
        check("lost_cnt",   int'(lost_cnt),   m_lost_cnt);
        check("err_cnt",    int'(err_cnt),    m_err_cnt);
    endtask

    task automatic step(input bit sw, input logic [7:0] fl, input bit er, input bit dn, input bit cl);
        rx_switch   = sw;
        rx_wr_flags = fl;
        rx_error    = er;
        rd_done     = dn;
        clean_all   = cl;
        @(posedge clk);
        model_update(sw, fl, er, dn, cl);
        #1;
        rx_switch   = 1'b0;
        rx_wr_flags = 8'h00;
        rx_error    = 1'b0;
        rd_done     = 1'b0;
        clean_all   = 1'b0;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_page"},    int'(wr_page),    0);
        check({tag, "_rd_page"},    int'(rd_page),    0);
        check({tag, "_filled_cnt"}, int'(filled_cnt), 0);
        check({tag, "_rx_pending"}, int'(rx_pending), 0);
        check({tag, "_rd_flags"},   int'(rd_flags),   0);
        check({tag, "_rx_abort"},   int'(rx_abort),   0);
        check({tag, "_rx_lost"},    int'(rx_lost),    0);
        check({tag, "_lost_cnt"},   int'(lost_cnt),   0);
        check({tag, "_err_cnt"},    int'(err_cnt),    0);
    endtask

    task automatic add_vec(input bit sw, input logic [7:0] fl, input bit dn, input bit cl,
                           input int wr, input int rd, input int filled, input int flags,
                           input bit lost, input bit abort);
        vec_t v;
        v.sw = sw; v.fl = fl; v.dn = dn; v.cl = cl;
        v.e_wr = wr; v.e_rd = rd; v.e_filled = filled; v.e_flags = flags;
        v.e_lost = lost; v.e_abort = abort;
        vecs.push_back(v);
    endtask

    initial begin
        reset_n     = 1'b0;
        rx_switch   = 1'b0;
        rx_wr_flags = 8'h00;
        rx_error    = 1'b0;
        rd_done     = 1'b0;
        clean_all   = 1'b0;
        model_reset();

        //       sw  flags  dn cl  wr rd fill flags lost abort
        add_vec(1, 8'h00, 0, 0,  1, 0, 1, 8'h00, 0, 0);
        add_vec(1, 8'h23, 0, 0,  2, 0, 2, 8'h00, 0, 0);
        add_vec(0, 8'h00, 1, 0,  2, 1, 1, 8'h23, 0, 0);
        add_vec(0, 8'h00, 1, 0,  2, 2, 0, 8'h00, 0, 0);
        add_vec(0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 1);
        add_vec(1, 8'h11, 0, 0,  1, 0, 1, 8'h11, 0, 0);
        add_vec(1, 8'h22, 0, 0,  2, 0, 2, 8'h11, 0, 0);
        add_vec(1, 8'h33, 0, 0,  3, 0, 3, 8'h11, 0, 0);
        add_vec(1, 8'h44, 0, 0,  3, 0, 3, 8'h11, 1, 0);
        add_vec(1, 8'h55, 1, 0,  0, 1, 3, 8'h22, 0, 0);
        add_vec(0, 8'h00, 1, 0,  0, 2, 2, 8'h33, 0, 0);
        add_vec(1, 8'h66, 0, 0,  1, 2, 3, 8'h33, 0, 0);
        add_vec(0, 8'h00, 1, 0,  1, 3, 2, 8'h55, 0, 0);
        add_vec(1, 8'h77, 0, 1,  0, 0, 0, 8'h00, 0, 1);
        add_vec(0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].sw, vecs[i].fl, 1'b0, vecs[i].dn, vecs[i].cl);
            check($sformatf("vec%0d_wr_page", i),    int'(wr_page),    vecs[i].e_wr);
            check($sformatf("vec%0d_rd_page", i),    int'(rd_page),    vecs[i].e_rd);
            check($sformatf("vec%0d_filled", i),     int'(filled_cnt), vecs[i].e_filled);
            check($sformatf("vec%0d_rd_flags", i),   int'(rd_flags),   vecs[i].e_flags);
            check($sformatf("vec%0d_rx_lost", i),    int'(rx_lost),    int'(vecs[i].e_lost));
            check($sformatf("vec%0d_rx_abort", i),   int'(rx_abort),   int'(vecs[i].e_abort));
        end
        check("lost_cnt_retained", int'(lost_cnt), 1);

        for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("err_cnt_saturated", int'(err_cnt), 8'hff);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("empty_rd_done_rd_page", int'(rd_page), 0);
        check("empty_rd_done_filled",  int'(filled_cnt), 0);

        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("lost_cnt_saturated", int'(lost_cnt), 8'hff);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3);
        end

        step(1'b1, 8'h5a, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'ha5, 1'b0, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 8'h3c, 1'b0, 1'b0, 1'b0);
        check("post_reset_rd_flags", int'(rd_flags), 8'h3c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
